// File: rtl/pdp11_bus_pkg.sv
// pdp11_bus_pkg: I/O page decode constants and line-clock interrupt
// identity shared by the bus fabric.
package pdp11_bus_pkg;

    localparam logic [8:0]  IO_PAGE = 9'h1FF;
    localparam logic [12:0] PSW_OFF = 13'o17776;
    localparam logic [12:0] SWR_OFF = 13'o17570;
    localparam logic [12:0] LKS_OFF = 13'o17546;
    localparam logic [2:0]  LTC_IPL = 3'd6;
    localparam logic [7:0]  LTC_VEC = 8'o100;

    // Word-granular match so both byte lanes of a register hit.
    function automatic logic reg_hit(
        input logic [12:0] off,
        input logic [12:0] base
    );
        return (off | 13'd1) == (base | 13'd1);
    endfunction

endpackage

// File: rtl/pdp11_bus_if.sv
// pdp11_bus_if: CPU-side bus cycle, interrupt arbitration and PSW
// signals between the pdp11 CPU (master) and the bus fabric (slave).
interface pdp11_bus_if;

    logic [21:0] bus_addr;
    logic [15:0] bus_data_in;
    logic [15:0] bus_data_out;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_byte_op;
    logic        bus_arbitrate;
    logic        bus_ack;
    logic        bus_error;
    logic        bus_int;
    logic [7:0]  bus_int_ipl;
    logic [7:0]  bus_int_vector;
    logic [7:0]  interrupt_ack_ipl;
    logic [15:0] psw;
    logic        psw_io_wr;

    modport master (
        output bus_addr, bus_data_in, bus_rd, bus_wr, bus_byte_op,
               bus_arbitrate, interrupt_ack_ipl, psw,
        input  bus_data_out, bus_ack, bus_error, bus_int,
               bus_int_ipl, bus_int_vector, psw_io_wr
    );

    modport slave (
        input  bus_addr, bus_data_in, bus_rd, bus_wr, bus_byte_op,
               bus_arbitrate, interrupt_ack_ipl, psw,
        output bus_data_out, bus_ack, bus_error, bus_int,
               bus_int_ipl, bus_int_vector, psw_io_wr
    );

endinterface

// File: rtl/pdp11_bus_ltc.sv
// pdp11_bus_ltc: KW11-L line clock -- tick divider, LKS monitor and
// interrupt-enable bits, and the resulting interrupt request.
module pdp11_bus_ltc #(
    parameter int LTC_DIV = 833333
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lks_wr,
    input  logic lks_wdata_ie,
    input  logic lks_ack,
    output logic lks_mon,
    output logic lks_ie,
    output logic ltc_req
);

    localparam int DW = (LTC_DIV > 1) ? $clog2(LTC_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(LTC_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          mon_q, mon_d;
    logic          ie_q, ie_d;
    logic          wrap;

    // Later assignments win: a CPU write overrides both ack and tick.
    always_comb begin
        wrap  = div_q == DIV_MAX;
        div_d = wrap ? '0 : div_q + DW'(1);
        mon_d = mon_q;
        ie_d  = ie_q;
        if (wrap)    mon_d = 1'b1;
        if (lks_ack) mon_d = 1'b0;
        if (lks_wr) begin
            mon_d = 1'b0;
            ie_d  = lks_wdata_ie;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            mon_q <= 1'b0;
            ie_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            mon_q <= mon_d;
            ie_q  <= ie_d;
        end
    end

    assign lks_mon = mon_q;
    assign lks_ie  = ie_q;
    assign ltc_req = mon_q & ie_q;

endmodule

// File: rtl/pdp11_bus.sv
// pdp11_bus: CPU bus fabric -- address decode, console/PSW/LKS
// registers, peripheral timeout and interrupt arbitration.
module pdp11_bus
    import pdp11_bus_pkg::*;
#(
    parameter logic [21:0] RAM_TOP    = 22'o01000000,
    parameter int          LTC_DIV    = 833333,
    parameter int          IO_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    pdp11_bus_if.slave  cpu,
    output logic [21:0] ram_addr,
    output logic [15:0] ram_data_out,
    input  logic [15:0] ram_data_in,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic        ram_byte_op,
    output logic [12:0] io_addr,
    output logic [15:0] io_data_out,
    input  logic [15:0] io_data_in,
    output logic        io_rd,
    output logic        io_wr,
    output logic        io_byte_op,
    input  logic        io_ack,
    input  logic        io_int_req,
    input  logic [2:0]  io_int_ipl,
    input  logic [7:0]  io_int_vector,
    output logic        io_int_ack,
    input  logic [15:0] switches,
    output logic [15:0] display
);

    localparam int TW = $clog2(IO_TIMEOUT + 2);
    localparam logic [TW-1:0] TMO = TW'(IO_TIMEOUT);

    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   display_q, display_d;
    logic          io_int_ack_q, io_int_ack_d;
    logic [12:0]   off;
    logic          strobe, is_rd, is_wr;
    logic          io_sel, ram_sel, int_sel, ext_sel, ext_cyc;
    logic          psw_hit, swr_hit, lks_hit, tmo_err;
    logic          lks_wr, lks_ack, lks_mon, lks_ie, ltc_req;
    logic          io_wins, win, win_ack;
    logic [2:0]    win_ipl;
    logic [7:0]    win_vec;
    logic [15:0]   rdata;

    assign ram_addr     = cpu.bus_addr;
    assign ram_data_out = cpu.bus_data_in;
    assign ram_byte_op  = cpu.bus_byte_op;
    assign io_addr      = cpu.bus_addr[12:0];
    assign io_data_out  = cpu.bus_data_in;
    assign io_byte_op   = cpu.bus_byte_op;

    // Strobes are gated by reset so every non-passthrough output is 0.
    always_comb begin
        off     = cpu.bus_addr[12:0];
        strobe  = reset & (cpu.bus_rd | cpu.bus_wr);
        is_wr   = strobe & cpu.bus_wr;
        is_rd   = strobe & ~cpu.bus_wr;
        io_sel  = cpu.bus_addr[21:13] == IO_PAGE;
        ram_sel = (cpu.bus_addr < RAM_TOP) & ~io_sel;
        psw_hit = io_sel & reg_hit(off, PSW_OFF);
        swr_hit = io_sel & reg_hit(off, SWR_OFF);
        lks_hit = io_sel & reg_hit(off, LKS_OFF);
        int_sel = psw_hit | swr_hit | lks_hit;
        ext_sel = io_sel & ~int_sel;
        ext_cyc = strobe & ext_sel;
        tmo_err = ext_cyc & ~io_ack & (tmo_q == TMO);
        lks_wr  = is_wr & lks_hit
                & ~(cpu.bus_byte_op & cpu.bus_addr[0]);
    end

    always_comb begin
        rdata = '0;
        if (is_rd) begin
            unique case (1'b1)
                ram_sel: rdata = ram_data_in;
                psw_hit: rdata = cpu.psw;
                swr_hit: rdata = switches;
                lks_hit: rdata = {8'h00, lks_mon, lks_ie, 6'h00};
                ext_sel: rdata = io_data_in;
                default: rdata = '0;
            endcase
        end
    end

    always_comb begin
        display_d = display_q;
        if (is_wr & swr_hit) begin
            if (!cpu.bus_byte_op)
                display_d = cpu.bus_data_in;
            else if (cpu.bus_addr[0])
                display_d[15:8] = cpu.bus_data_in[15:8];
            else
                display_d[7:0] = cpu.bus_data_in[7:0];
        end
        tmo_d = tmo_q;
        if (!ext_cyc || io_ack)
            tmo_d = '0;
        else if (tmo_q <= TMO)
            tmo_d = tmo_q + TW'(1);
    end

    // Line clock keeps ties; the peripheral must be strictly higher.
    always_comb begin
        io_wins = io_int_req & (~ltc_req | (io_int_ipl > LTC_IPL));
        win     = reset & (ltc_req | io_int_req);
        win_ipl = io_wins ? io_int_ipl
                : (ltc_req ? LTC_IPL : 3'd0);
        win_vec = io_wins ? io_int_vector
                : (ltc_req ? LTC_VEC : 8'd0);
        win_ack = win & cpu.bus_arbitrate
                & cpu.interrupt_ack_ipl[win_ipl];
        lks_ack      = win_ack & ~io_wins;
        io_int_ack_d = win_ack & io_wins;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q        <= '0;
            display_q    <= '0;
            io_int_ack_q <= 1'b0;
        end else begin
            tmo_q        <= tmo_d;
            display_q    <= display_d;
            io_int_ack_q <= io_int_ack_d;
        end
    end

    pdp11_bus_ltc #(
        .LTC_DIV (LTC_DIV)
    ) u_ltc (
        .clk          (clk),
        .rst_n        (reset),
        .lks_wr       (lks_wr),
        .lks_wdata_ie (cpu.bus_data_in[6]),
        .lks_ack      (lks_ack),
        .lks_mon      (lks_mon),
        .lks_ie       (lks_ie),
        .ltc_req      (ltc_req)
    );

    assign ram_rd = is_rd & ram_sel;
    assign ram_wr = is_wr & ram_sel;
    assign io_rd  = is_rd & ext_sel;
    assign io_wr  = is_wr & ext_sel;

    assign cpu.bus_data_out   = rdata;
    assign cpu.bus_ack        = (strobe & (ram_sel | int_sel))
                              | (ext_cyc & io_ack);
    assign cpu.bus_error      = (strobe & ~ram_sel & ~io_sel) | tmo_err;
    assign cpu.psw_io_wr      = is_wr & psw_hit;
    assign cpu.bus_int        = win & (win_ipl > cpu.psw[7:5]);
    assign cpu.bus_int_ipl    = win ? {5'b0, win_ipl} : 8'd0;
    assign cpu.bus_int_vector = win ? win_vec : 8'd0;

    assign io_int_ack = io_int_ack_q;
    assign display    = display_q;

endmodule

// File: tb/tb_pdp11_bus.sv
// tb_pdp11_bus: randomized self-checking bench for the pdp11 bus fabric,
// checked against a region/register model built from address arithmetic.
`timescale 1ns/1ps
module tb_pdp11_bus;

    localparam int          LTC     = 4;
    localparam logic [21:0] IO_BASE = 22'o17760000;
    localparam logic [21:0] A_PSW   = 22'o17777776;
    localparam logic [21:0] A_SWR   = 22'o17777570;
    localparam logic [21:0] A_LKS   = 22'o17777546;
    localparam logic [21:0] A_EXT   = 22'o17777560;
    localparam int R_RAM = 0, R_EXT = 1, R_PSW = 2;
    localparam int R_SWR = 3, R_LKS = 4, R_NONE = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [21:0] ram_addr;
    logic [15:0] ram_data_out, ram_data_in;
    logic        ram_rd, ram_wr, ram_byte_op;
    logic [12:0] io_addr;
    logic [15:0] io_data_out, io_data_in;
    logic        io_rd, io_wr, io_byte_op, io_ack;
    logic        io_int_req, io_int_ack;
    logic [2:0]  io_int_ipl;
    logic [7:0]  io_int_vector;
    logic [15:0] switches, display;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] m_disp;

    pdp11_bus_if bi ();

    pdp11_bus #(.LTC_DIV(LTC)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu           (bi.slave),
        .ram_addr      (ram_addr),
        .ram_data_out  (ram_data_out),
        .ram_data_in   (ram_data_in),
        .ram_rd        (ram_rd),
        .ram_wr        (ram_wr),
        .ram_byte_op   (ram_byte_op),
        .io_addr       (io_addr),
        .io_data_out   (io_data_out),
        .io_data_in    (io_data_in),
        .io_rd         (io_rd),
        .io_wr         (io_wr),
        .io_byte_op    (io_byte_op),
        .io_ack        (io_ack),
        .io_int_req    (io_int_req),
        .io_int_ipl    (io_int_ipl),
        .io_int_vector (io_int_vector),
        .io_int_ack    (io_int_ack),
        .switches      (switches),
        .display       (display)
    );

    always #5 clk = ~clk;

    function automatic int region(input logic [21:0] a);
        int off;
        if (a >= IO_BASE) begin
            off = int'(a - IO_BASE) & ~1;
            if (off == 'o17776) return R_PSW;
            if (off == 'o17570) return R_SWR;
            if (off == 'o17546) return R_LKS;
            return R_EXT;
        end
        return (a < 22'o1000000) ? R_RAM : R_NONE;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [21:0] a, input logic rd,
                         input logic wr, input logic bo,
                         input logic [15:0] d);
        bi.bus_addr = a;
        bi.bus_rd = rd;
        bi.bus_wr = wr;
        bi.bus_byte_op = bo;
        bi.bus_data_in = d;
        #1;
    endtask

    task automatic idle();
        bi.bus_rd = 1'b0;
        bi.bus_wr = 1'b0;
        bi.bus_byte_op = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        io_int_req = 1'b1;
        io_int_ipl = 3'd7;
        drive(22'o001000, 1'b1, 1'b0, 1'b0, 16'h0);
        n_vec++;
        if ({bi.bus_ack, bi.bus_error, ram_rd, bi.bus_int} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ctl got %b want 0000",
                     {bi.bus_ack, bi.bus_error, ram_rd, bi.bus_int});
        end
        n_vec++;
        if ({display, io_int_ack, bi.bus_int_ipl} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_regs got disp=%h ack=%b ipl=%h want 0",
                     display, io_int_ack, bi.bus_int_ipl);
        end
        n_vec++;
        if (ram_addr !== 22'o001000) begin
            n_bad++;
            $display("FAIL reset_pass got %o want 001000", ram_addr);
        end
        io_int_req = 1'b0;
        idle();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ram();
        ram_data_in = 16'o123456;
        drive(22'o001000, 1'b1, 1'b0, 1'b0, 16'h0);
        n_vec++;
        if ({ram_rd, bi.bus_ack, bi.bus_error} !== 3'b110 ||
            bi.bus_data_out !== 16'o123456) begin
            n_bad++;
            $display("FAIL ram_read got rd/ack/err=%b data=%o want 110 123456",
                     {ram_rd, bi.bus_ack, bi.bus_error}, bi.bus_data_out);
        end
        drive(22'o01000000, 1'b1, 1'b0, 1'b0, 16'h0);
        n_vec++;
        if ({ram_rd, bi.bus_ack, bi.bus_error} !== 3'b001) begin
            n_bad++;
            $display("FAIL ram_top got rd/ack/err=%b want 001",
                     {ram_rd, bi.bus_ack, bi.bus_error});
        end
        idle();
        tick();
    endtask

    task automatic test_decode_random();
        logic [21:0] a;
        logic [1:0]  op;
        logic        bo;
        logic [15:0] d, exp_d;
        logic [3:0]  exp_s, got_s;
        int          r, mode;
        io_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 0)
                a = 22'($urandom_range(0, 'o777777));
            else if (mode == 1)
                a = IO_BASE + 22'($urandom_range(0, 'o17777));
            else
                a = 22'($urandom);
            r = region(a);
            if (r == R_PSW || r == R_SWR || r == R_LKS) begin
                a = a - 22'o100;
                r = region(a);
            end
            op = 2'($urandom_range(1, 3));
            bo = 1'($urandom);
            d = 16'($urandom);
            ram_data_in = 16'($urandom);
            io_data_in = 16'($urandom);
            drive(a, op[0], op[1], bo, d);
            exp_s = {r == R_RAM && !op[1], r == R_RAM && op[1],
                     r == R_EXT && !op[1], r == R_EXT && op[1]};
            got_s = {ram_rd, ram_wr, io_rd, io_wr};
            n_vec++;
            if (got_s !== exp_s ||
                bi.bus_ack !== (r == R_RAM || r == R_EXT) ||
                bi.bus_error !== (r == R_NONE)) begin
                n_bad++;
                $display("FAIL decode a=%o got s=%b ack=%b err=%b want s=%b r=%0d",
                         a, got_s, bi.bus_ack, bi.bus_error, exp_s, r);
            end
            n_vec++;
            if (io_addr !== a[12:0] || ram_byte_op !== bo ||
                io_data_out !== d) begin
                n_bad++;
                $display("FAIL passthru got io_addr=%o bo=%b want %o %b",
                         io_addr, ram_byte_op, a[12:0], bo);
            end
            if (op == 2'b01) begin
                exp_d = (r == R_RAM) ? ram_data_in :
                        (r == R_EXT) ? io_data_in : 16'h0;
                n_vec++;
                if (bi.bus_data_out !== exp_d) begin
                    n_bad++;
                    $display("FAIL rdata a=%o got %h want %h",
                             a, bi.bus_data_out, exp_d);
                end
            end
            idle();
            tick();
        end
        io_ack = 1'b0;
    endtask

    task automatic test_psw();
        bi.psw = 16'($urandom);
        drive(A_PSW, 1'b1, 1'b0, 1'b0, 16'h0);
        n_vec++;
        if (bi.bus_data_out !== bi.psw || bi.bus_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL psw_read got %h ack=%b want %h ack=1",
                     bi.bus_data_out, bi.bus_ack, bi.psw);
        end
        drive(A_PSW, 1'b0, 1'b1, 1'b0, 16'o000340);
        n_vec++;
        if ({bi.psw_io_wr, bi.bus_ack} !== 2'b11) begin
            n_bad++;
            $display("FAIL psw_wr got wr/ack=%b want 11",
                     {bi.psw_io_wr, bi.bus_ack});
        end
        tick();
        idle();
        n_vec++;
        if (bi.psw_io_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL psw_wr_pulse got %b want 0", bi.psw_io_wr);
        end
        bi.psw = 16'h0;
    endtask

    task automatic test_swr();
        logic [21:0] a;
        logic        bo;
        logic [15:0] d;
        switches = 16'o177000;
        drive(A_SWR, 1'b1, 1'b0, 1'b0, 16'h0);
        n_vec++;
        if (bi.bus_data_out !== 16'o177000) begin
            n_bad++;
            $display("FAIL swr_read got %o want 177000", bi.bus_data_out);
        end
        m_disp = 16'($urandom);
        drive(A_SWR, 1'b0, 1'b1, 1'b0, m_disp);
        tick();
        idle();
        m_disp = {8'o055, m_disp[7:0]};
        drive(A_SWR | 22'd1, 1'b0, 1'b1, 1'b1, 16'o055 << 8);
        tick();
        idle();
        n_vec++;
        if (display !== m_disp) begin
            n_bad++;
            $display("FAIL swr_byte_hi got %h want %h", display, m_disp);
        end
        for (int i = 0; i < 8; i++) begin
            a = A_SWR | 22'($urandom_range(0, 1));
            bo = 1'($urandom);
            d = 16'($urandom);
            if (!bo)
                m_disp = d;
            else if (a[0])
                m_disp = {d[15:8], m_disp[7:0]};
            else
                m_disp = {m_disp[15:8], d[7:0]};
            drive(a, 1'b0, 1'b1, bo, d);
            tick();
            idle();
            n_vec++;
            if (display !== m_disp) begin
                n_bad++;
                $display("FAIL swr_wr a=%o bo=%b got %h want %h",
                         a, bo, display, m_disp);
            end
        end
    endtask

    task automatic wait_ltc(output logic got);
        got = 1'b0;
        for (int i = 0; i < LTC && !got; i++) begin
            tick();
            got = bi.bus_int;
        end
    endtask

    task automatic test_lks();
        logic got;
        int   hits;
        bi.psw = 16'h0;
        drive(A_LKS, 1'b0, 1'b1, 1'b0, 16'o000100);
        tick();
        drive(A_LKS, 1'b1, 1'b0, 1'b0, 16'h0);
        n_vec++;
        if (bi.bus_data_out !== 16'o000100) begin
            n_bad++;
            $display("FAIL lks_read got %o want 000100", bi.bus_data_out);
        end
        idle();
        wait_ltc(got);
        n_vec++;
        if (got !== 1'b1 || bi.bus_int_ipl !== 8'd6 ||
            bi.bus_int_vector !== 8'o100) begin
            n_bad++;
            $display("FAIL ltc_int got int=%b ipl=%0d vec=%o want 1 6 100",
                     got, bi.bus_int_ipl, bi.bus_int_vector);
        end
        bi.interrupt_ack_ipl = 8'h40;
        bi.bus_arbitrate = 1'b0;
        tick();
        bi.interrupt_ack_ipl = 8'h00;
        #1;
        n_vec++;
        if (bi.bus_int !== 1'b1) begin
            n_bad++;
            $display("FAIL ack_no_arb got int=%b want 1", bi.bus_int);
        end
        bi.interrupt_ack_ipl = 8'h40;
        bi.bus_arbitrate = 1'b1;
        tick();
        bi.interrupt_ack_ipl = 8'h00;
        bi.bus_arbitrate = 1'b0;
        #1;
        n_vec++;
        if (bi.bus_int !== 1'b0) begin
            n_bad++;
            $display("FAIL ltc_ack got int=%b want 0", bi.bus_int);
        end
        drive(A_LKS | 22'd1, 1'b0, 1'b1, 1'b1, 16'h0);
        tick();
        drive(A_LKS, 1'b1, 1'b0, 1'b0, 16'h0);
        n_vec++;
        if ((bi.bus_data_out & 16'o177577) !== 16'o000100) begin
            n_bad++;
            $display("FAIL lks_odd_byte got %o want 000100 (bit7 masked)",
                     bi.bus_data_out);
        end
        idle();
        bi.psw = 16'o000340;
        hits = 0;
        for (int i = 0; i < LTC + 2; i++) begin
            tick();
            if (bi.bus_int) hits++;
        end
        n_vec++;
        if (hits !== 0 || bi.bus_int_ipl !== 8'd6) begin
            n_bad++;
            $display("FAIL psw_mask got %0d int cycles ipl=%0d want 0 6",
                     hits, bi.bus_int_ipl);
        end
        bi.psw = 16'h0;
        #1;
        n_vec++;
        if (bi.bus_int !== 1'b1) begin
            n_bad++;
            $display("FAIL psw_unmask got int=%b want 1", bi.bus_int);
        end
    endtask

    task automatic test_io_timeout();
        int          n;
        int          dly;
        logic [15:0] exp_d;
        io_ack = 1'b0;
        drive(A_EXT, 1'b1, 1'b0, 1'b0, 16'h0);
        n = 0;
        while (!bi.bus_error && n < 40) begin
            tick();
            n++;
        end
        n_vec++;
        if (n !== 16) begin
            n_bad++;
            $display("FAIL io_timeout got %0d cycles want 16", n);
        end
        tick();
        n_vec++;
        if (bi.bus_error !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pulse got err=%b want 0", bi.bus_error);
        end
        idle();
        tick();
        for (int k = 0; k < 4; k++) begin
            dly = (k == 0) ? 2 : (k == 1) ? 15 : int'($urandom_range(0, 15));
            drive(A_EXT, 1'b1, 1'b0, 1'b0, 16'h0);
            for (int i = 0; i < dly; i++) tick();
            exp_d = 16'($urandom);
            io_data_in = exp_d;
            io_ack = 1'b1;
            #1;
            n_vec++;
            if ({bi.bus_ack, bi.bus_error} !== 2'b10 ||
                bi.bus_data_out !== exp_d) begin
                n_bad++;
                $display("FAIL io_ack dly=%0d got ack/err=%b data=%h want 10 %h",
                         dly, {bi.bus_ack, bi.bus_error}, bi.bus_data_out,
                         exp_d);
            end
            io_ack = 1'b0;
            idle();
            tick();
        end
    endtask

    task automatic test_io_int();
        logic       got;
        logic [2:0] ipl, pri;
        logic [7:0] vec;
        drive(A_LKS, 1'b0, 1'b1, 1'b0, 16'h0);
        tick();
        idle();
        io_int_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ipl = 3'($urandom);
            pri = 3'($urandom);
            vec = 8'($urandom);
            io_int_ipl = ipl;
            io_int_vector = vec;
            bi.psw = {8'h0, pri, 5'h0};
            #1;
            n_vec++;
            if (bi.bus_int !== (ipl > pri) ||
                bi.bus_int_ipl !== {5'b0, ipl} ||
                bi.bus_int_vector !== vec) begin
                n_bad++;
                $display("FAIL io_arb ipl=%0d pri=%0d got int=%b ipl=%0d vec=%o",
                         ipl, pri, bi.bus_int, bi.bus_int_ipl,
                         bi.bus_int_vector);
            end
        end
        io_int_req = 1'b0;
        bi.psw = 16'h0;
        drive(A_LKS, 1'b0, 1'b1, 1'b0, 16'o000100);
        tick();
        idle();
        wait_ltc(got);
        vec = 8'($urandom);
        io_int_vector = vec;
        io_int_req = 1'b1;
        io_int_ipl = 3'd6;
        #1;
        n_vec++;
        if (got !== 1'b1 || bi.bus_int_vector !== 8'o100) begin
            n_bad++;
            $display("FAIL tie got rdy=%b vec=%o want 1 100",
                     got, bi.bus_int_vector);
        end
        io_int_ipl = 3'd7;
        #1;
        n_vec++;
        if (bi.bus_int_vector !== vec || bi.bus_int_ipl !== 8'd7) begin
            n_bad++;
            $display("FAIL io_wins got vec=%o ipl=%0d want %o 7",
                     bi.bus_int_vector, bi.bus_int_ipl, vec);
        end
        bi.interrupt_ack_ipl = 8'h80;
        bi.bus_arbitrate = 1'b1;
        tick();
        bi.interrupt_ack_ipl = 8'h00;
        bi.bus_arbitrate = 1'b0;
        n_vec++;
        if (io_int_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL io_int_ack got %b want 1", io_int_ack);
        end
        tick();
        n_vec++;
        if (io_int_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL io_int_ack_pulse got %b want 0", io_int_ack);
        end
        io_int_req = 1'b0;
        #1;
        n_vec++;
        if (bi.bus_int_vector !== 8'o100) begin
            n_bad++;
            $display("FAIL ltc_kept got vec=%o want 100", bi.bus_int_vector);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        m_disp = 16'($urandom) | 16'h1;
        drive(A_SWR, 1'b0, 1'b1, 1'b0, m_disp);
        tick();
        drive(A_EXT, 1'b1, 1'b0, 1'b0, 16'h0);
        io_ack = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b0;
        #1;
        n_vec++;
        if ({display, bi.bus_error, io_rd, bi.bus_int} !== 19'd0 ||
            ram_addr !== A_EXT) begin
            n_bad++;
            $display("FAIL reset_mid got disp=%h err=%b rd=%b int=%b addr=%o",
                     display, bi.bus_error, io_rd, bi.bus_int, ram_addr);
        end
        tick();
        reset = 1'b1;
        #1;
        n = 0;
        while (!bi.bus_error && n < 40) begin
            tick();
            n++;
        end
        n_vec++;
        if (n !== 16) begin
            n_bad++;
            $display("FAIL reset_tmo got %0d cycles want 16", n);
        end
        idle();
        tick();
        drive(A_LKS, 1'b1, 1'b0, 1'b0, 16'h0);
        n_vec++;
        if ((bi.bus_data_out & 16'o000100) !== 16'h0 || bi.bus_int !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_lks got %o int=%b want ie=0 int=0",
                     bi.bus_data_out, bi.bus_int);
        end
        idle();
    endtask

    initial begin
        bi.bus_addr = '0;
        bi.bus_data_in = '0;
        bi.bus_rd = 1'b0;
        bi.bus_wr = 1'b0;
        bi.bus_byte_op = 1'b0;
        bi.bus_arbitrate = 1'b0;
        bi.interrupt_ack_ipl = '0;
        bi.psw = '0;
        ram_data_in = '0;
        io_data_in = '0;
        io_ack = 1'b0;
        io_int_req = 1'b0;
        io_int_ipl = '0;
        io_int_vector = '0;
        switches = '0;
        m_disp = '0;
        #3;
        test_reset();
        test_ram();
        test_decode_random();
        test_psw();
        test_swr();
        test_lks();
        test_io_timeout();
        test_io_int();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
